// File: rtl/swb_bank_arbiter_pkg.sv
// Shared types and sizing for the switch-back bank arbiter.
// Defaults: channel and bank counts and the beat count of one line return.
// Provides the clog2_min1 helper, which keeps index fields at least one bit wide.
package swb_bank_arbiter_pkg;

  localparam int MPC_NUM_CH    = 3;
  localparam int MPC_NUM_BANK  = 4;
  localparam int MPC_SWB_BEATS = 2;  // 256-bit line / 128-bit word

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [clog2_min1(MPC_NUM_BANK)-1:0] mpc_bank_id_t;
  typedef logic [clog2_min1(MPC_NUM_CH)-1:0]   mpc_ch_id_t;

  typedef enum logic {
    SWB_IDLE = 1'b0,
    SWB_XFER = 1'b1
  } swb_state_e;

endpackage

// File: rtl/swb_bank_arbiter_rr_arb.sv
// Rotating-priority picker: grants the first requester at or after ptr_i, wrapping.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when the grant is consumed.
// Ports: req_i (N requests), ptr_i (priority start), gnt_o (one-hot grant), gnt_idx_o (grant index).
module swb_rr_arb
  import swb_bank_arbiter_pkg::*;
#(
  parameter  int N  = 3,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  always_comb begin
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/swb_bank_arbiter.sv
// Grants cache banks to channel kob heads and sequences the multi-beat line return.
// Latency: first beat one cycle after the request, ack on the last beat, one idle bubble per bank.
// Backpressure: a beat holds valid/bank/idx stable until ch_beat_ready; the beat counter only moves on accept.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   ch_swb_req / ch_swb_bank_id    per-channel head request and target bank
//   ch_swb_ack                     per-channel head retire pulse (same cycle as the last accepted beat)
//   ch_beat_valid / ch_beat_ready  per-channel beat handshake
//   ch_beat_bank / idx / last      crossbar select, word index, final-beat flag
//   bank_busy / bank_owner         per-bank ownership status (owner reads 0 when idle)
module swb_bank_arbiter
  import swb_bank_arbiter_pkg::*;
#(
  parameter  int NUM_CH   = MPC_NUM_CH,
  parameter  int NUM_BANK = MPC_NUM_BANK,
  parameter  int BEATS    = MPC_SWB_BEATS,
  localparam int BW       = clog2_min1(NUM_BANK),
  localparam int CW       = clog2_min1(NUM_CH),
  localparam int IW       = clog2_min1(BEATS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      ch_swb_req,
  input  logic [NUM_CH*BW-1:0]   ch_swb_bank_id,
  output logic [NUM_CH-1:0]      ch_swb_ack,
  output logic [NUM_CH-1:0]      ch_beat_valid,
  input  logic [NUM_CH-1:0]      ch_beat_ready,
  output logic [NUM_CH*BW-1:0]   ch_beat_bank,
  output logic [NUM_CH*IW-1:0]   ch_beat_idx,
  output logic [NUM_CH-1:0]      ch_beat_last,
  output logic [NUM_BANK-1:0]    bank_busy,
  output logic [NUM_BANK*CW-1:0] bank_owner
);

  logic [NUM_BANK-1:0] xfer;
  logic [NUM_BANK-1:0] last_arr;
  logic [CW-1:0]       owner_arr [NUM_BANK];
  logic [IW-1:0]       beat_arr  [NUM_BANK];
  logic [NUM_CH-1:0]   ch_busy;

  // A channel already owned by some bank must not be offered to another one.
  always_comb begin
    ch_busy = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (xfer[b] && (owner_arr[b] == CW'(c))) ch_busy[c] = 1'b1;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    swb_state_e        state_q;
    logic [CW-1:0]     owner_q;
    logic [CW-1:0]     rr_q;
    logic [IW-1:0]     beat_q;
    logic [CW-1:0]     pick_idx;
    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] pick_gnt;
    logic              beat_last;
    logic              beat_fire;

    always_comb begin
      cand = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cand[c] = ch_swb_req[c] && (ch_swb_bank_id[c*BW +: BW] == BW'(b)) && !ch_busy[c];
      end
    end

    swb_rr_arb #(.N(NUM_CH)) u_arb (
      .req_i     (cand),
      .ptr_i     (rr_q),
      .gnt_o     (pick_gnt),
      .gnt_idx_o (pick_idx)
    );

    assign beat_last = (beat_q == IW'(BEATS - 1));
    assign beat_fire = (state_q == SWB_XFER) && ch_beat_ready[owner_q];

    // Returning to IDLE after the last beat is the bubble that lets the kob
    // pop its head before this channel can be a candidate again.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= SWB_IDLE;
        owner_q <= '0;
        beat_q  <= '0;
        rr_q    <= '0;
      end else begin
        case (state_q)
          SWB_IDLE: begin
            if (|pick_gnt) begin
              state_q <= SWB_XFER;
              owner_q <= pick_idx;
              beat_q  <= '0;
              rr_q    <= (pick_idx == CW'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
            end
          end
          SWB_XFER: begin
            if (beat_fire) begin
              if (beat_last) begin
                state_q <= SWB_IDLE;
                beat_q  <= '0;
              end else begin
                beat_q  <= beat_q + 1'b1;
              end
            end
          end
          default: state_q <= SWB_IDLE;
        endcase
      end
    end

    assign xfer[b]      = (state_q == SWB_XFER);
    assign last_arr[b]  = beat_last;
    assign owner_arr[b] = owner_q;
    assign beat_arr[b]  = beat_q;

    // The owning kob head must stay put until it is retired.
    a_head_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == SWB_XFER) |->
        (ch_swb_req[owner_q] && (ch_swb_bank_id[owner_q*BW +: BW] == BW'(b))));
  end

  // Ownership is one-hot per channel, so OR-merging the banks is a clean mux.
  always_comb begin
    ch_swb_ack    = '0;
    ch_beat_valid = '0;
    ch_beat_bank  = '0;
    ch_beat_idx   = '0;
    ch_beat_last  = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (xfer[b] && (owner_arr[b] == CW'(c))) begin
          ch_beat_valid[c]          = 1'b1;
          ch_beat_bank[c*BW +: BW] |= BW'(b);
          ch_beat_idx[c*IW +: IW]  |= beat_arr[b];
          ch_beat_last[c]          |= last_arr[b];
          ch_swb_ack[c]            |= last_arr[b] & ch_beat_ready[c];
        end
      end
    end
  end

  always_comb begin
    bank_busy  = xfer;
    bank_owner = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      bank_owner[b*CW +: CW] = xfer[b] ? owner_arr[b] : '0;
    end
  end

endmodule
